// File: rtl/pwm_compare.sv
// PWM comparator fed by the high bits of a free-running tick counter.
// Duty updates arrive over valid/ready, sit in a shadow register and are applied
// only at a counter wrap, so every period is whole. A small FSM aligns start/stop
// to period boundaries and period_start_o pulses once per period while running.
// Optional feature: define PWM_DEADTIME_EN to add complementary output pwm_n_o
// with a programmable dead time (dt_i cycles, both outputs low) after each phase change.
module pwm_compare #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DT_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             duty_valid_i,
  output logic             duty_ready_o,
  output logic             pwm_o,
  output logic             period_start_o,
  output logic             busy_o
`ifdef PWM_DEADTIME_EN
  ,
  input  logic [DT_WIDTH-1:0] dt_i,
  output logic                pwm_n_o
`endif
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StStopping} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_count_q;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;
  logic             busy_q, busy_d;

  logic wrap;
  logic accept;
  logic running_d;
  logic raw;

  // A dead-time counter narrower than one bit makes no sense.
  if (DT_WIDTH < 1) begin : g_dt_width_chk
    $error("DT_WIDTH must be at least 1");
  end

  // Wrap fires once on the transition into zero; a counter parked at zero stays quiet.
  assign wrap   = (count_i == '0) && (prev_count_q != '0);
  assign accept = duty_valid_i && !pending_q;

  // Period-aligned start/stop sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (enable_i) state_d = StArmed;
      StArmed: begin
        if (!enable_i)  state_d = StIdle;
        else if (wrap)  state_d = StRun;
      end
      StRun:      if (!enable_i) state_d = StRun == StRun ? StStopping : StRun;
      StStopping: begin
        // A re-raised enable keeps running without a gap, even on the wrap itself.
        if (enable_i)   state_d = StRun;
        else if (wrap)  state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase
  end

  // Shadow/active duty bookkeeping; a load and an accept can never coincide.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = duty_i;
      pending_d = 1'b1;
    end
  end

  // Compare against the state and duty that this very edge installs, so the
  // count-zero sample of a new period already reflects the new settings.
  always_comb begin
    running_d      = (state_d == StRun) || (state_d == StStopping);
    raw            = running_d && (count_i < active_d);
    period_start_d = wrap && (state_d == StRun);
    busy_d         = (state_d != StIdle);
  end

`ifdef PWM_DEADTIME_EN
  logic [1:0]          phase_q, phase_d;
  logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
  logic                pwm_n_q, pwm_n_d;

  // Any phase change (including off -> on) restarts the dead time; a phase that
  // ends before the dead time expires is never shown.
  always_comb begin
    phase_d  = {running_d && raw, running_d && !raw};
    dt_cnt_d = dt_cnt_q;
    if (phase_d != phase_q) begin
      dt_cnt_d = dt_i;
    end else if (dt_cnt_q != '0) begin
      dt_cnt_d = dt_cnt_q - 1'b1;
    end
    pwm_d   = phase_d[1] && (dt_cnt_d == '0);
    pwm_n_d = phase_d[0] && (dt_cnt_d == '0);
  end

  // Dead-time state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= 2'b00;
      dt_cnt_q <= '0;
      pwm_n_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      dt_cnt_q <= dt_cnt_d;
      pwm_n_q  <= pwm_n_d;
    end
  end

  assign pwm_n_o = pwm_n_q;
`else
  // Plain single-phase output.
  always_comb begin
    pwm_d = raw;
  end
`endif

  // All core state, including the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      prev_count_q   <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_count_q   <= count_i;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      busy_q         <= busy_d;
    end
  end

  assign duty_ready_o   = !pending_q;
  assign pwm_o          = pwm_q;
  assign period_start_o = period_start_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare: the bench drives count_i itself, one value per
// clock, and checks outputs 1 time unit after each rising edge. After applying
// count c, pwm_o is expected to reflect the compare for c.
module tb_pwm_compare;

  localparam int unsigned W   = 8;
  localparam int unsigned DTW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] count_i;
  logic         enable_i;
  logic [W-1:0] duty_i;
  logic         duty_valid_i;
  logic         duty_ready_o;
  logic         pwm_o;
  logic         period_start_o;
  logic         busy_o;
`ifdef PWM_DEADTIME_EN
  logic [DTW-1:0] dt_i;
  logic           pwm_n_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_compare #(
    .WIDTH    (W),
    .DT_WIDTH (DTW)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .count_i        (count_i),
    .enable_i       (enable_i),
    .duty_i         (duty_i),
    .duty_valid_i   (duty_valid_i),
    .duty_ready_o   (duty_ready_o),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .busy_o         (busy_o)
`ifdef PWM_DEADTIME_EN
    ,
    .dt_i           (dt_i),
    .pwm_n_o        (pwm_n_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int c);
    count_i = c[W-1:0];
    tick();
  endtask

  // Apply counts lo..hi; pwm_o must be high exactly when count < thr.
  task automatic sweep(input int lo, input int hi, input int thr, input string tag);
    for (int c = lo; c <= hi; c++) begin
      step(c);
      check(tag, {31'd0, pwm_o}, {31'd0, (c < thr)});
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    enable_i     = 1'b1;
    duty_i       = '0;
    duty_valid_i = 1'b0;
    count_i      = '0;
`ifdef PWM_DEADTIME_EN
    dt_i         = '0;
`endif

    // 1: held in reset while enabled and the counter ramps.
    for (int c = 0; c < 10; c++) begin
      step(c);
      check("rst_pwm", {31'd0, pwm_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_ready", {31'd0, duty_ready_o}, 32'd1);
      check("rst_ps", {31'd0, period_start_o}, 32'd0);
    end
    rst_n = 1'b1;
    step(10);
    check("armed_busy", {31'd0, busy_o}, 32'd1);
    sweep(11, 255, 0, "armed_pwm");
    check("armed_ps", {31'd0, period_start_o}, 32'd0);
    step(0);
    check("first_wrap_ps", {31'd0, period_start_o}, 32'd1);
    check("first_wrap_pwm", {31'd0, pwm_o}, 32'd0);
    step(1);
    check("ps_one_cycle", {31'd0, period_start_o}, 32'd0);

    // 2: duty 64 accepted mid-period, applied at the next wrap.
    sweep(2, 99, 0, "pre_accept");
    check("ready_before", {31'd0, duty_ready_o}, 32'd1);
    duty_i = 8'd64; duty_valid_i = 1'b1;
    step(100);
    duty_valid_i = 1'b0;
    check("ready_after_accept", {31'd0, duty_ready_o}, 32'd0);
    sweep(101, 255, 0, "shadow_not_applied");
    check("ready_pending", {31'd0, duty_ready_o}, 32'd0);
    step(0);
    check("d64_wrap_pwm", {31'd0, pwm_o}, 32'd1);
    check("d64_ready", {31'd0, duty_ready_o}, 32'd1);
    check("d64_ps", {31'd0, period_start_o}, 32'd1);
    sweep(1, 255, 64, "duty64");

    // 3: duty 200 offered on the wrap cycle lands one period later.
    duty_i = 8'd200; duty_valid_i = 1'b1;
    step(0);
    duty_valid_i = 1'b0;
    check("same_wrap_pwm", {31'd0, pwm_o}, 32'd1);
    check("same_wrap_ready", {31'd0, duty_ready_o}, 32'd0);
    sweep(1, 255, 64, "same_wrap_keep64");
    step(0);
    check("d200_ready", {31'd0, duty_ready_o}, 32'd1);
    sweep(1, 49, 200, "duty200");
    duty_i = 8'd128; duty_valid_i = 1'b1;
    step(50);
    duty_valid_i = 1'b0;
    check("d200_mid", {31'd0, pwm_o}, 32'd1);
    sweep(51, 255, 200, "duty200_tail");

    // 4: stop at count 30; the period completes, then IDLE without a pulse.
    step(0);
    check("d128_wrap", {31'd0, pwm_o}, 32'd1);
    sweep(1, 29, 128, "duty128");
    enable_i = 1'b0;
    step(30);
    check("stop_pwm", {31'd0, pwm_o}, 32'd1);
    check("stop_busy", {31'd0, busy_o}, 32'd1);
    sweep(31, 255, 128, "stopping");
    check("stopping_busy", {31'd0, busy_o}, 32'd1);
    step(0);
    check("idle_pwm", {31'd0, pwm_o}, 32'd0);
    check("idle_ps", {31'd0, period_start_o}, 32'd0);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    enable_i = 1'b1;
    step(1);
    check("rearm_busy", {31'd0, busy_o}, 32'd1);
    sweep(2, 255, 0, "rearmed");
    step(0);
    check("restart_ps", {31'd0, period_start_o}, 32'd1);
    check("restart_pwm", {31'd0, pwm_o}, 32'd1);
    sweep(1, 19, 128, "run128");
    enable_i = 1'b0;
    sweep(20, 39, 128, "stop_window");
    check("stop_window_busy", {31'd0, busy_o}, 32'd1);
    enable_i = 1'b1;
    sweep(40, 255, 128, "resumed");
    step(0);
    check("cont_ps", {31'd0, period_start_o}, 32'd1);
    check("cont_pwm", {31'd0, pwm_o}, 32'd1);
    check("cont_busy", {31'd0, busy_o}, 32'd1);

    // 5: duty 0 and duty 255 boundaries, then a counter parked at zero.
    sweep(1, 9, 128, "pre_d0");
    duty_i = 8'd0; duty_valid_i = 1'b1;
    step(10);
    duty_valid_i = 1'b0;
    sweep(11, 255, 128, "pre_d0_tail");
    step(0);
    check("d0_wrap_pwm", {31'd0, pwm_o}, 32'd0);
    check("d0_wrap_ps", {31'd0, period_start_o}, 32'd1);
    sweep(1, 9, 0, "duty0");
    duty_i = 8'd255; duty_valid_i = 1'b1;
    step(10);
    duty_valid_i = 1'b0;
    check("duty0_mid", {31'd0, pwm_o}, 32'd0);
    sweep(11, 255, 0, "duty0_tail");
    step(0);
    check("d255_wrap_pwm", {31'd0, pwm_o}, 32'd1);
    sweep(1, 255, 255, "duty255");
    step(0);
    check("hold0_first_ps", {31'd0, period_start_o}, 32'd1);
    step(0);
    check("hold0_ps_a", {31'd0, period_start_o}, 32'd0);
    step(0);
    check("hold0_ps_b", {31'd0, period_start_o}, 32'd0);
    check("hold0_pwm", {31'd0, pwm_o}, 32'd1);

    // Reset mid-period drops outputs at once and discards the pending duty.
    sweep(1, 99, 255, "pre_reset");
    duty_i = 8'd64; duty_valid_i = 1'b1;
    step(100);
    duty_valid_i = 1'b0;
    check("pre_reset_ready", {31'd0, duty_ready_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_pwm", {31'd0, pwm_o}, 32'd0);
    check("async_busy", {31'd0, busy_o}, 32'd0);
    check("async_ready", {31'd0, duty_ready_o}, 32'd1);
    step(101);
    rst_n = 1'b1;
    sweep(102, 255, 0, "post_reset_armed");
    step(0);
    check("post_reset_ps", {31'd0, period_start_o}, 32'd1);
    check("post_reset_pwm", {31'd0, pwm_o}, 32'd0);
    sweep(1, 255, 0, "shadow_discarded");

`ifdef PWM_DEADTIME_EN
    // 6: dead time 3 with duty 64, then dead time 15 with duty 2.
    dt_i = 4'd3;
    duty_i = 8'd64; duty_valid_i = 1'b1;
    step(0);
    duty_valid_i = 1'b0;
    sweep(1, 255, 0, "dt_prep");
    for (int c = 0; c < 256; c++) begin
      if (c == 100) begin
        duty_i = 8'd2; duty_valid_i = 1'b1;
      end
      step(c);
      duty_valid_i = 1'b0;
      check("dt3_p", {31'd0, pwm_o}, {31'd0, (c >= 3 && c < 64)});
      check("dt3_n", {31'd0, pwm_n_o}, {31'd0, (c >= 67)});
    end
    dt_i = 4'd15;
    for (int c = 0; c < 256; c++) begin
      step(c);
      check("dt15_p", {31'd0, pwm_o}, 32'd0);
      check("dt15_n", {31'd0, pwm_n_o}, {31'd0, (c >= 17)});
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_compare.md
Name: pwm_compare

Overview:
- Downstream consumer of the free-running tick counter. Compares the counter's high bits (`count_i`) against a duty value and drives a PWM output.
- Duty updates arrive over a valid/ready handshake. They are shadow-buffered and applied only at a period boundary (counter wrap), so no glitched or partial periods occur.
- Start and stop are period-aligned via a small FSM. A one-cycle pulse marks each period start for downstream sequencing.

Parameters:
- WIDTH, 8: width of `count_i` and duty; equals the counter's HIGH_WIDTH.
- DT_WIDTH, 4: width of the dead-time count. Used only when PWM_DEADTIME_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- count_i  input  WIDTH  high bits of the tick counter
- enable_i  input  1  level request to run PWM
- duty_i  input  WIDTH  new duty (high-phase compare value)
- duty_valid_i  input  1  duty_i valid
- duty_ready_o  output  1  shadow register free
- pwm_o  output  1  PWM output, registered
- period_start_o  output  1  one-cycle pulse at each wrap while running
- busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - pwm_o=0, period_start_o=0, busy_o=0, duty_ready_o=1
  - active duty=0, shadow empty, prev_count=0, FSM=IDLE
  - Reset mid-period aborts immediately: outputs low, shadow discarded.
- Wrap detect:
  - prev_count registers count_i every cycle.
  - wrap = (count_i==0) && (prev_count!=0). A counter held at 0 produces no repeated wraps.
- Handshake:
  - duty_ready_o = !pending.
  - Accept when duty_valid_i && duty_ready_o: shadow<=duty_i, pending<=1.
  - At wrap with pending=1: active<=shadow, pending<=0.
  - Accept in the same cycle as a wrap: the value goes to the shadow and is applied at the *next* wrap.
  - duty_ready_o stays 0 until the load completes. Updates are accepted in every FSM state; in IDLE/ARMED they load at the next wrap as usual.
- FSM states and transitions:
  - IDLE: enable_i=1 -> ARMED.
  - ARMED: wrap -> RUN. enable_i=0 -> IDLE.
  - RUN: enable_i=0 -> STOPPING. Otherwise stay.
  - STOPPING: wrap -> IDLE (current period completes). enable_i=1 before the wrap -> RUN, with no gap.
- period_start_o:
  - Pulses in the cycle after any wrap that leaves the FSM in RUN, including the ARMED->RUN transition.
  - Does not pulse on the STOPPING->IDLE wrap.
- Compare:
  - raw = (state in RUN or STOPPING) && (count_i < active).
  - The RUN state and active duty used are the values updated by the same wrap edge.
  - pwm_o<=raw: one cycle latency from count_i.
- Boundaries:
  - duty=0: pwm_o constantly 0.
  - duty=2^WIDTH-1: high for all counts except max; 100% is unreachable by design.
  - Comparison is unsigned, WIDTH bits. No arithmetic overflow is possible.
- busy_o = (state!=IDLE), registered with the state.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - Adds ports `dt_i` (input, DT_WIDTH) and `pwm_n_o` (output, 1, reset 0).
  - pwm_n_o is the complement phase of raw while running.
  - After every raw transition, both pwm_o and pwm_n_o are held low for dt_i cycles (dead-time counter), then the new phase asserts.
  - If raw toggles again before the dead time expires, the counter restarts; the skipped phase is suppressed.
  - dt_i=0 gives plain complementary outputs.
  - In IDLE/ARMED both outputs are 0.
- Undefined: no dt_i or pwm_n_o ports; pwm_o as above.

Test Plan:
1. Reset with enable_i=1 and count ramping 0..255 -> pwm_o=0, busy_o=0 during reset; after release ARMED, then RUN at first wrap, period_start_o pulse 1 cycle later.
2. Duty 64 accepted mid-period, counter sweep -> pwm_o unchanged until wrap; then high for counts 0..63 (delayed 1 cycle), low for 64..255; duty_ready_o=0 from accept to the load.
3. duty_valid_i in the same cycle as a wrap (duty 200) -> value not applied that period; applied at the following wrap.
4. Drop enable_i at count 30 with duty 128 -> pwm_o still high through 127, low to wrap; at wrap IDLE, no period_start_o, busy_o falls. Re-raise enable_i in STOPPING -> continuous RUN.
5. Duty 0 and 255 -> pwm_o never high / low only at count 255.
6. (PWM_DEADTIME_EN, dt_i=3, duty 64) -> both outputs low 3 cycles after each edge. Then dt_i=15 with duty 2 -> high phase suppressed, pwm_o never asserts.
